// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduler: state encoding, default widths, counter sizing.
// The GAP state is only present when UART_TX_GAP_EN is defined.
package uart_pkg;

    localparam int UART_WIDTH = 8;
    localparam int UART_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FLUSH_RD
`ifdef UART_TX_GAP_EN
        , S_GAP
`endif
    } sched_state_t;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2w(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_sched_timer.sv
// Loadable down-counter with a done flag; shared by the ACK timeout and the inter-frame gap.
module uart_sched_timer
    import uart_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// Drains the TX FIFO into the UART shifter one frame at a time, with flush, ACK timeout and counters.
// Optional inter-frame idle gap enabled by defining UART_TX_GAP_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int WIDTH       = UART_WIDTH,
    parameter int CNT_W       = UART_CNT_W,
    parameter int ACK_TIMEOUT = 64,
    parameter int GAP_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flush,
    input  logic             fifo_empty,
    output logic             fifo_r_e,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [WIDTH-1:0] tx_data,
    output logic             sched_busy,
    output logic             ack_err,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = clog2w(TMR_MAX + 1);

    sched_state_t     state;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    // Timer is loaded on the edge that enters the timed state, so it reads
    // N-1 on the first cycle there and reports done on the N-th.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TMR_W'(ACK_TIMEOUT - 1);
        if (state == S_START) begin
            tmr_load = 1'b1;
        end
`ifdef UART_TX_GAP_EN
        if (state == S_WAIT_DONE && !tx_busy) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(GAP_CYCLES - 1);
        end
`endif
    end

    uart_sched_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            fifo_r_e   <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            sched_busy <= 1'b0;
            ack_err    <= 1'b0;
            sent_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            fifo_r_e <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Flush wins over enable; fifo_empty is only trusted here.
                    if (flush && !fifo_empty) begin
                        state      <= S_FLUSH_RD;
                        fifo_r_e   <= 1'b1;
                        sched_busy <= 1'b1;
                    end else if (enable && !fifo_empty && !tx_busy) begin
                        state      <= S_READ;
                        fifo_r_e   <= 1'b1;
                        sched_busy <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    tx_data  <= fifo_data;
                    tx_start <= 1'b1;
                    state    <= S_START;
                end
                S_START: begin
                    sent_cnt <= sent_cnt + CNT_W'(1);
                    state    <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (tmr_done) begin
                        ack_err    <= 1'b1;
                        drop_cnt   <= drop_cnt + CNT_W'(1);
                        state      <= S_IDLE;
                        sched_busy <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
`ifdef UART_TX_GAP_EN
                        state      <= S_GAP;
`else
                        state      <= S_IDLE;
                        sched_busy <= 1'b0;
`endif
                    end
                end
`ifdef UART_TX_GAP_EN
                S_GAP: begin
                    if (tmr_done) begin
                        state      <= S_IDLE;
                        sched_busy <= 1'b0;
                    end
                end
`endif
                S_FLUSH_RD: begin
                    drop_cnt   <= drop_cnt + CNT_W'(1);
                    state      <= S_IDLE;
                    sched_busy <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    sched_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
